// File: rtl/lut_mult_arbiter.sv
// Round-robin share of one pipelined Q-format constant multiplier, with a credit-guarded result FIFO.
// Define LUT_MULT_ARB_SAT_EN to clamp results to the signed IN_W range instead of wrapping.
module lut_mult_arbiter #(
    parameter int NREQ       = 4,
    parameter int IN_W       = 32,
    parameter int CONST_W    = 30,
    parameter int FRAC       = 15,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*IN_W-1:0]    req_a,
    input  logic [NREQ*CONST_W-1:0] req_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IN_W-1:0]         out_data,
    output logic [ID_W-1:0]         out_id,
    output logic                    busy
);

    localparam int PW    = IN_W + CONST_W;
    localparam int AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);

    logic [ID_W-1:0]        ptr;
    logic                   gnt_any;
    logic [ID_W-1:0]        gnt_idx;
    logic                   credit_ok;
    logic                   accept;
    logic [OCC_W-1:0]       inflight;

    logic [IN_W-1:0]        sel_a;
    logic [CONST_W-1:0]     sel_b;
    logic signed [PW-1:0]   prod;

    logic [MUL_LAT-1:0]     st_v;
    logic signed [PW-1:0]   st_p  [MUL_LAT];
    logic [ID_W-1:0]        st_id [MUL_LAT];

    logic signed [PW-1:0]   shifted;
    logic [IN_W-1:0]        result;

    logic [IN_W-1:0]        mem_d  [FIFO_DEPTH];
    logic [ID_W-1:0]        mem_id [FIFO_DEPTH];
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [AW:0]            fifo_count;
    logic                   push;
    logic                   pop;

    // Credit uses registered occupancy only, so a pop this cycle frees a slot next cycle.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < MUL_LAT; s++) begin
            inflight = inflight + OCC_W'(st_v[s]);
        end
    end

    assign credit_ok = (OCC_W'(fifo_count) + inflight) < OCC_W'(FIFO_DEPTH);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    assign accept    = gnt_any & credit_ok & ~rst;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign sel_a = req_a[gnt_idx*IN_W +: IN_W];
    assign sel_b = req_b[gnt_idx*CONST_W +: CONST_W];
    assign prod  = PW'($signed(sel_a)) * PW'($signed(sel_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            st_v <= '0;
        end else begin
            st_v[0] <= accept;
            for (int s = 1; s < MUL_LAT; s++) begin
                st_v[s] <= st_v[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        st_p[0]  <= prod;
        st_id[0] <= gnt_idx;
        for (int s = 1; s < MUL_LAT; s++) begin
            st_p[s]  <= st_p[s-1];
            st_id[s] <= st_id[s-1];
        end
    end

    assign shifted = st_p[MUL_LAT-1] >>> FRAC;

`ifdef LUT_MULT_ARB_SAT_EN
    // Out of range whenever the bits above the result sign are not a pure sign extension.
    always_comb begin
        result = shifted[IN_W-1:0];
        if (!((&shifted[PW-1:IN_W-1]) || !(|shifted[PW-1:IN_W-1]))) begin
            result = shifted[PW-1] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
        end
    end
`else
    assign result = shifted[IN_W-1:0];
`endif

    assign push      = st_v[MUL_LAT-1];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wptr]  <= result;
            mem_id[wptr] <= st_id[MUL_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_data = out_valid ? mem_d[rptr]  : '0;
    assign out_id   = out_valid ? mem_id[rptr] : '0;
    assign busy     = (|st_v) | out_valid;

endmodule

// File: tb/tb_lut_mult_arbiter.sv
// Scoreboard bench for lut_mult_arbiter at default parameters.
module tb_lut_mult_arbiter;

    localparam int NREQ = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [119:0] req_b;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
    logic         busy;

    logic [31:0]  a_arr   [4];
    logic [29:0]  b_arr   [4];
    logic [31:0]  exp_arr [4];

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } sb_t;

    sb_t sbq [$];
    int  grant_log [$];
    int  vectors     = 0;
    int  miscompares = 0;
    sb_t push_e;
    sb_t pop_e;

    assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    lut_mult_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Accept watcher: every handshake pushes the hand-computed result for that requester.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (req_ready != '0) chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    push_e.id   = 2'(i);
                    push_e.data = exp_arr[i];
                    sbq.push_back(push_e);
                    grant_log.push_back(i);
                end
            end
        end
    end

    // Result monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("result_expected", 32'(sbq.size()), 32'd1);
            end else begin
                pop_e = sbq.pop_front();
                chk("result_data", out_data, pop_e.data);
                chk("result_id", 32'(out_id), 32'(pop_e.id));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [29:0] b,
                           input logic [31:0] e);
        a_arr[i]   = a;
        b_arr[i]   = b;
        exp_arr[i] = e;
    endtask

    task automatic one_shot(input logic [3:0] mask, input string name);
        tick;
        req_valid = mask;
        tick;
        req_valid = '0;
        wait_idle(name);
    endtask

    initial begin
        set_req(0, 32'd10,         30'h8000,  32'd10);
        set_req(1, 32'hFFFF_FFF9,  30'h4000,  32'hFFFF_FFFC);
        set_req(2, 32'd100,        30'h4000,  32'd50);
        set_req(3, 32'd3,          30'h18000, 32'd9);
        req_valid = 4'hF;

        repeat (3) tick;
        at_neg;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  out_data,       32'd0);
        chk("reset_out_id",    32'(out_id),    32'd0);
        chk("reset_busy",      32'(busy),      32'd0);

        // Round-robin from reset, all four requesters valid for six cycles
        tick;
        rst = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc > 0) tick;
            if (cyc == 6) req_valid = '0;
            at_neg;
            if (cyc == 0) chk("reset_exit_grant", 32'(req_ready), 32'h1);
            chk("rr_out_valid", 32'(out_valid), (cyc >= 3 && cyc <= 8) ? 32'd1 : 32'd0);
        end
        chk("rr_grant_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk("rr_grant_order", 32'(grant_log[i]), 32'(i % 4));
        end
        wait_idle("rr_drain");

        // Basic product and latency: requester 2 alone
        tick;
        req_valid = 4'b0100;
        at_neg;
        chk("basic_grant", 32'(req_ready), 32'h4);
        tick;
        req_valid = '0;
        at_neg;
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_early1", 32'(out_valid), 32'd0);
        tick;
        at_neg;
        chk("basic_early2", 32'(out_valid), 32'd0);
        tick;
        at_neg;
        chk("basic_out_valid", 32'(out_valid), 32'd1);
        chk("basic_out_data", out_data, 32'd50);
        chk("basic_out_id", 32'(out_id), 32'd2);
        wait_idle("basic_drain");

        set_req(2, 32'hFFFF_FFFD, 30'h4000, 32'hFFFF_FFFE);
        one_shot(4'b0100, "floor_drain");

`ifdef LUT_MULT_ARB_SAT_EN
        set_req(2, 32'h7FFF_FFFF, 30'h10000, 32'h7FFF_FFFF);
        one_shot(4'b0100, "sat_pos_drain");
        set_req(2, 32'h8000_0000, 30'h10000, 32'h8000_0000);
        one_shot(4'b0100, "sat_neg_drain");
`else
        set_req(2, 32'h7FFF_FFFF, 30'h10000, 32'hFFFF_FFFE);
        one_shot(4'b0100, "wrap_pos_drain");
        set_req(2, 32'h8000_0000, 30'h10000, 32'h0000_0000);
        one_shot(4'b0100, "wrap_neg_drain");
`endif
        set_req(2, 32'd100, 30'h4000, 32'd50);

        // Backpressure: pointer sits at 3
        grant_log.delete();
        tick;
        out_ready = 1'b0;
        req_valid = 4'hF;
        for (int cyc = 0; cyc < 12; cyc++) begin
            at_neg;
            tick;
        end
        at_neg;
        chk("bp_accepts", 32'(grant_log.size()), 32'd4);
        chk("bp_stalled", 32'(req_ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        tick;
        out_ready = 1'b1;
        at_neg;
        chk("bp_no_early_grant", 32'(req_ready), 32'd0);
        tick;
        at_neg;
        chk("bp_resume_grant", 32'(req_ready), 32'h8);
        tick;
        req_valid = '0;
        wait_idle("bp_drain");
        chk("bp_total_grants", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk("bp_grant_order", 32'(grant_log[i]), 32'((i + 3) % 4));
        end

        // Reset mid-flight: three accepts, then reset with two in the pipe
        grant_log.delete();
        tick;
        out_ready = 1'b0;
        req_valid = 4'hF;
        tick;
        tick;
        tick;
        rst = 1'b1;
        req_valid = '0;
        at_neg;
        chk("mid_accepts", 32'(grant_log.size()), 32'd3);
        chk("mid_busy_before", 32'(busy), 32'd1);
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1110;
        at_neg;
        chk("mid_grant_lowest", 32'(req_ready), 32'h2);
        chk("mid_busy_after", 32'(busy), 32'd0);
        chk("mid_no_out_valid0", 32'(out_valid), 32'd0);
        tick;
        req_valid = '0;
        at_neg;
        chk("mid_no_out_valid1", 32'(out_valid), 32'd0);
        tick;
        at_neg;
        chk("mid_no_out_valid2", 32'(out_valid), 32'd0);
        tick;
        at_neg;
        chk("mid_new_result", 32'(out_valid), 32'd1);
        chk("mid_new_id", 32'(out_id), 32'd1);
        chk("mid_new_data", out_data, 32'hFFFF_FFFC);

        wait_idle("final_drain");
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lut_mult_arbiter.md
# lut_mult_arbiter

Round-robin scheduler that shares one pipelined fixed-point constant multiplier among `NREQ` requesters in the image-compression datapath, for example DCT/quantisation lanes. Each request carries an operand and a Q-format constant, and each result is tagged with the ID of its requester. A result FIFO absorbs downstream backpressure. Credit accounting guarantees that no in-flight product is ever dropped.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `IN_W`, 32: signed operand and result width.
- `CONST_W`, 30: signed constant width.
- `FRAC`, 15: fractional bits of the constant.
- `MUL_LAT`, 2: multiplier pipeline stages (≥1).
- `FIFO_DEPTH`, 4: result FIFO entries (power of two, ≥2).
- `ID_W`, max(1, $clog2(NREQ)): tag width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero.
- `req_a`  in  NREQ*IN_W  operands; requester i occupies bits [i*IN_W +: IN_W].
- `req_b`  in  NREQ*CONST_W  constants; requester i occupies bits [i*CONST_W +: CONST_W].
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  IN_W  result.
- `out_id`  out  ID_W  index of the requester that produced the result.
- `busy`  out  1  high when any product is in flight or the FIFO is non-empty.

## Operation
- **Handshake.** A request from requester i is accepted in any cycle where `req_valid[i] & req_ready[i]`. A requester holds `req_a`/`req_b` stable while valid and unaccepted.
- **Arbitration.** Round-robin with pointer `ptr`.
  - Grant goes to the first valid requester at or after `ptr`, in cyclic order.
  - `req_ready` is combinational from `req_valid`, `ptr` and the current credit state. At most one bit is set.
  - After a grant to i, `ptr` becomes (i+1) mod NREQ. With no grant, `ptr` is unchanged.
- **Credit.** `credit = FIFO_DEPTH − fifo_count − inflight`, computed from registered values.
  - A grant is allowed only when credit > 0.
  - A pop in the current cycle does not raise credit until the next cycle.
- **Arithmetic.**
  - Full product `p = signed(a) × signed(b)`, width IN_W+CONST_W.
  - Shift `r = p >>> FRAC` (arithmetic shift, truncates toward −∞).
  - Result is the low IN_W bits of r (wrap), unless the saturation option is compiled in (see Configuration).
- **Pipeline and FIFO.**
  - The ID tag travels with the operands through all MUL_LAT stages, so no reordering is possible.
  - The final stage writes into the FIFO. The FIFO is show-ahead: `out_data`/`out_id` are valid whenever `out_valid` is high.
  - A pop occurs on `out_valid & out_ready`.
- **Simultaneous events.**
  - FIFO push and pop in the same cycle leave `fifo_count` unchanged.
  - The FIFO can never overflow, because of the credit rule.
  - A pop while empty is impossible: `out_valid` is low.
- **Reset (including mid-operation).**
  - All in-flight products are discarded and the FIFO is cleared.
  - `ptr` is set to 0.
- **Reset values.**
  - `req_ready` = 0, forced while `rst` is high.
  - `out_valid` = 0, `out_data` = 0, `out_id` = 0, `busy` = 0.

## Timing
- **Latency.** A request accepted in cycle t produces a result at the FIFO head with `out_valid` high in cycle t+MUL_LAT+1, provided the FIFO was empty.
- **Throughput.** One accept per cycle when credit allows and `out_ready` is held high.
  - With `out_ready` stuck at 0, exactly FIFO_DEPTH accepts occur before all of `req_ready` falls to 0.
- **Recovery after pops.** After the first pop in cycle c, `req_ready` can reassert in cycle c+1.
- **Reset exit.** In the first cycle after `rst` deasserts, a grant is possible to the lowest-indexed valid requester.

## Configuration
- `LUT_MULT_ARB_SAT_EN` defined:
  - r is clamped to [−2^(IN_W−1), 2^(IN_W−1)−1] before truncation.
  - An extra comparator sits in the final pipeline stage; latency is unchanged.
- `LUT_MULT_ARB_SAT_EN` undefined: the result is the plain low IN_W bits of r (two's-complement wrap).

## Test plan
All scenarios use the defaults (IN_W=32, FRAC=15, MUL_LAT=2, FIFO_DEPTH=4) with `out_ready`=1 unless stated.
- **Basic product.** Requester 2 alone sends a=100, b=0x4000 (0.5). Required: `out_data`=50, `out_id`=2, `out_valid` 3 cycles after accept.
- **Floor rounding.** a=−3, b=0x4000. Required: `out_data`=0xFFFFFFFE (−2).
- **Round-robin order.** All 4 requesters valid continuously from reset. Required: grants in order 0,1,2,3,0,1; results emerge in the same ID order, one per cycle.
- **Backpressure.** `out_ready`=0 with all requesters valid. Required: exactly 4 accepts, then `req_ready`=0 indefinitely; `busy`=1. After raising `out_ready`, the 4 results drain in order and grants resume one cycle after the first pop.
- **Saturation.** a=0x7FFFFFFF, b=0x10000 (2.0). Required: `out_data`=0x7FFFFFFF with `LUT_MULT_ARB_SAT_EN` defined, 0xFFFFFFFE without it.
- **Reset mid-flight.** Accept 3 requests, assert `rst` for 1 cycle with 2 products in the pipeline. Required: no `out_valid` afterwards, `busy`=0, and the next grant goes to the lowest-indexed valid requester.
